// File: rtl/rv_lsu_bus_adapter.sv
// Load/store adapter: turns the single-cycle dmem port into a req/ack bus access
// with byte lanes, stalls the pipeline until completion and formats load data.
module rv_lsu_bus_adapter #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        i_lsu_clk,
    input  logic        i_lsu_rstn,
    input  logic        i_lsu_dmem_re,
    input  logic        i_lsu_dmem_we,
    input  logic [31:0] i_lsu_dmem_a,
    input  logic [31:0] i_lsu_dmem_wd,
    input  logic [2:0]  i_lsu_dmem_bytectrl,
    output logic [31:0] o_lsu_dmem_rd,
    output logic        o_lsu_stall,
    output logic        o_lsu_err,
    output logic        o_lsu_bus_req,
    output logic        o_lsu_bus_we,
    output logic [31:0] o_lsu_bus_addr,
    output logic [3:0]  o_lsu_bus_be,
    output logic [31:0] o_lsu_bus_wdata,
    input  logic        i_lsu_bus_ack,
    input  logic [31:0] i_lsu_bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t      state_q;
    logic        req_q, we_q, to_q;
    logic [29:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q, cap_q;
    logic [7:0]  cnt_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;

    logic        access, illegal, misal, bad;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    logic [31:0] fmt;

    assign access  = i_lsu_dmem_re | i_lsu_dmem_we;
    assign illegal = (i_lsu_dmem_bytectrl == 3'b011) || (i_lsu_dmem_bytectrl == 3'b110) ||
                     (i_lsu_dmem_bytectrl == 3'b111);
    assign misal   = ((i_lsu_dmem_bytectrl[1:0] == 2'b01) && i_lsu_dmem_a[0]) ||
                     ((i_lsu_dmem_bytectrl[1:0] == 2'b10) && (i_lsu_dmem_a[1:0] != 2'b00));
    assign bad     = illegal | misal;

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = '0;
        if (i_lsu_dmem_we) begin
            wdata_d = i_lsu_dmem_wd;
            case (i_lsu_dmem_bytectrl[1:0])
                2'b00: begin
                    be_d    = 4'b0001 << i_lsu_dmem_a[1:0];
                    wdata_d = {4{i_lsu_dmem_wd[7:0]}};
                end
                2'b01: begin
                    be_d    = i_lsu_dmem_a[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{i_lsu_dmem_wd[15:0]}};
                end
                default: be_d = 4'b1111;
            endcase
        end
    end

    // Load formatting works on the latched offset/size, never on live inputs.
    always_comb begin
        case (off_q)
            2'd0:    sel_b = cap_q[7:0];
            2'd1:    sel_b = cap_q[15:8];
            2'd2:    sel_b = cap_q[23:16];
            default: sel_b = cap_q[31:24];
        endcase
        sel_h = off_q[1] ? cap_q[31:16] : cap_q[15:0];
        case (f3_q)
            3'b000:  fmt = {{24{sel_b[7]}}, sel_b};
            3'b100:  fmt = {24'd0, sel_b};
            3'b001:  fmt = {{16{sel_h[15]}}, sel_h};
            3'b101:  fmt = {16'd0, sel_h};
            default: fmt = cap_q;
        endcase
    end

    always_ff @(posedge i_lsu_clk or negedge i_lsu_rstn) begin
        if (!i_lsu_rstn) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            to_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            cap_q   <= '0;
            cnt_q   <= '0;
            off_q   <= '0;
            f3_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    to_q  <= 1'b0;
                    cnt_q <= '0;
                    if (access && !bad) begin
                        req_q   <= 1'b1;
                        we_q    <= i_lsu_dmem_we;
                        addr_q  <= i_lsu_dmem_a[31:2];
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                        off_q   <= i_lsu_dmem_a[1:0];
                        f3_q    <= i_lsu_dmem_bytectrl;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_lsu_bus_ack) begin
                        cap_q   <= i_lsu_bus_rdata;
                        req_q   <= 1'b0;
                        state_q <= S_DONE;
                    end else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
                        cap_q   <= '0;
                        req_q   <= 1'b0;
                        to_q    <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_lsu_stall     = ((state_q == S_IDLE) && access && !bad) || (state_q == S_REQ);
    assign o_lsu_err       = ((state_q == S_IDLE) && access && bad) || ((state_q == S_DONE) && to_q);
    assign o_lsu_dmem_rd   = (state_q == S_DONE) ? fmt : '0;
    assign o_lsu_bus_req   = req_q;
    assign o_lsu_bus_we    = we_q;
    assign o_lsu_bus_addr  = {addr_q, 2'b00};
    assign o_lsu_bus_be    = be_q;
    assign o_lsu_bus_wdata = wdata_q;

endmodule
